// File: rtl/matrix_3x3.sv
// 3x3 neighbourhood window generator for a raster 8-bit pixel stream.
// Two cascaded line buffers plus a three-column shift window, 2-clock latency.

module matrix_3x3_row (
  input  logic       video_clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       clr_old_i,
  input  logic       clr_mid_i,
  input  logic [7:0] px_i,
  output logic [2:0][7:0] win_o
);
  // win_q[0] is the oldest column, win_q[2] the newest
  logic [2:0][7:0] win_q;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else if (en_i) begin
      win_q[2] <= px_i;
      win_q[1] <= clr_mid_i ? 8'd0 : win_q[2];
      win_q[0] <= clr_old_i ? 8'd0 : win_q[1];
    end
  end

  assign win_o = win_q;
endmodule

module matrix_3x3_gen #(
  parameter int IMG_WIDTH = 640,
  parameter int COL_W     = 10
) (
  input  logic       video_clk,
  input  logic       rst_n,
  input  logic       video_vs,
  input  logic       video_de,
  input  logic [7:0] video_data,
  output logic       matrix_vs,
  output logic       matrix_de,
  output logic [7:0] matrix11,
  output logic [7:0] matrix12,
  output logic [7:0] matrix13,
  output logic [7:0] matrix21,
  output logic [7:0] matrix22,
  output logic [7:0] matrix23,
  output logic [7:0] matrix31,
  output logic [7:0] matrix32,
  output logic [7:0] matrix33
);
  localparam int STAGES = 2;
  localparam int AW     = $clog2(IMG_WIDTH);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH);

  logic [STAGES:1] vld_pipe_q, vs_pipe_q;
  logic [COL_W-1:0] col_cnt_q, c1_q;
  logic [1:0]       row_cnt_q;
  logic [7:0]       p1_q, r1_q, r2_q;
  logic [7:0]       lb0 [IMG_WIDTH];
  logic [7:0]       lb1 [IMG_WIDTH];

  logic          de_fall, vs_rise, col_ok;
  logic [AW-1:0] addr;

  assign de_fall = vld_pipe_q[1] & ~video_de;
  assign vs_rise = video_vs & ~vs_pipe_q[1];
  assign col_ok  = col_cnt_q < COL_MAX;
  assign addr    = col_cnt_q[AW-1:0];

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      vs_pipe_q  <= '0;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], video_de};
      vs_pipe_q  <= {vs_pipe_q[STAGES-1:1], video_vs};
      if (video_de) begin
        if (col_cnt_q != COL_MAX) col_cnt_q <= col_cnt_q + 1'b1;
      end else if (de_fall) begin
        col_cnt_q <= '0;
      end
      // frame start takes priority over the end-of-line increment
      if (vs_rise)                         row_cnt_q <= '0;
      else if (de_fall && row_cnt_q != 2'd2) row_cnt_q <= row_cnt_q + 1'b1;
    end
  end

  // Line buffers are never reset; row masking hides stale contents.
  always_ff @(posedge video_clk) begin
    if (video_de && col_ok) begin
      lb0[addr] <= video_data;
      lb1[addr] <= lb0[addr];
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q <= '0;
      c1_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
    end else if (video_de) begin
      p1_q <= video_data;
      c1_q <= col_cnt_q;
      r2_q <= (col_ok && row_cnt_q != 2'd0) ? lb0[addr] : 8'd0;
      r1_q <= (col_ok && row_cnt_q == 2'd2) ? lb1[addr] : 8'd0;
    end
  end

  logic [2:0][7:0]       new_col;
  logic [2:0][2:0][7:0]  win;
  logic                  clr_old, clr_mid;

  assign new_col[0] = r1_q;
  assign new_col[1] = r2_q;
  assign new_col[2] = p1_q;
  assign clr_mid    = (c1_q == '0);
  assign clr_old    = (c1_q <= COL_W'(1));

  for (genvar r = 0; r < 3; r++) begin : g_row
    matrix_3x3_row u_row (
      .video_clk (video_clk),
      .rst_n     (rst_n),
      .en_i      (vld_pipe_q[1]),
      .clr_old_i (clr_old),
      .clr_mid_i (clr_mid),
      .px_i      (new_col[r]),
      .win_o     (win[r])
    );
  end

  assign matrix_de = vld_pipe_q[STAGES];
  assign matrix_vs = vs_pipe_q[STAGES];
  assign matrix11  = win[0][0];
  assign matrix12  = win[0][1];
  assign matrix13  = win[0][2];
  assign matrix21  = win[1][0];
  assign matrix22  = win[1][1];
  assign matrix23  = win[1][2];
  assign matrix31  = win[2][0];
  assign matrix32  = win[2][1];
  assign matrix33  = win[2][2];
endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Scoreboard bench for matrix_3x3_gen with a 4-pixel line buffer.
// Expected windows come from an image model indexed by row/column.

module tb_matrix_3x3_gen;
  localparam int IMG_W = 4;

  logic video_clk = 1'b0;
  logic rst_n, video_vs, video_de;
  logic [7:0] video_data;
  logic matrix_vs, matrix_de;
  logic [7:0] matrix11, matrix12, matrix13, matrix21, matrix22, matrix23;
  logic [7:0] matrix31, matrix32, matrix33;

  matrix_3x3_gen #(.IMG_WIDTH(IMG_W), .COL_W(3)) dut (
    .video_clk(video_clk), .rst_n(rst_n), .video_vs(video_vs),
    .video_de(video_de), .video_data(video_data),
    .matrix_vs(matrix_vs), .matrix_de(matrix_de),
    .matrix11(matrix11), .matrix12(matrix12), .matrix13(matrix13),
    .matrix21(matrix21), .matrix22(matrix22), .matrix23(matrix23),
    .matrix31(matrix31), .matrix32(matrix32), .matrix33(matrix33)
  );

  always #5 video_clk = ~video_clk;

  int checks = 0;
  int errors = 0;
  logic [71:0] sb_q[$];
  int          len_q[$];
  logic [7:0]  img [16][8];
  int          mrow, mcol;
  logic        m_pde, m_pvs;

  logic [71:0] win;
  assign win = {matrix11, matrix12, matrix13, matrix21, matrix22, matrix23,
                matrix31, matrix32, matrix33};

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask

  // Pixel k lines above the newest one, at input column cc.
  function automatic logic [7:0] ref_px(int k, int cc);
    if (cc < 0 || cc >= 8) return 8'd0;
    if (k > 0 && (mrow - k < 0 || cc >= IMG_W)) return 8'd0;
    if (mrow - k >= 16) return 8'd0;
    return img[mrow-k][cc];
  endfunction

  // Apply one cycle of input and advance the model, then step past the edge.
  task automatic drive(input logic de, input logic vs, input logic [7:0] d);
    logic [71:0] e;
    video_de = de; video_vs = vs; video_data = d;
    if (de) begin
      if (mrow < 16 && mcol < 8) img[mrow][mcol] = d;
      e = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e = {e[63:0], ref_px(2 - i, mcol - (2 - j))};
      sb_q.push_back(e);
      mcol++;
    end
    if (m_pde && !de) begin mcol = 0; mrow++; end
    if (vs && !m_pvs) mrow = 0;
    m_pde = de; m_pvs = vs;
    @(posedge video_clk); #1;
  endtask

  task automatic line(input int n, input int base, input logic vs_end);
    for (int c = 0; c < n; c++) drive(1'b1, 1'b0, 8'(base + c));
    len_q.push_back(n);
    drive(1'b0, vs_end, 8'd0);
  endtask

  task automatic vs_pulse();
    drive(1'b0, 1'b1, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
  endtask

  logic vh0, vh1, dh0, dh1;
  int run = 0;

  always @(posedge video_clk) begin
    if (!rst_n) begin
      vh0 <= 1'b0; vh1 <= 1'b0; dh0 <= 1'b0; dh1 <= 1'b0;
    end else begin
      vh0 <= video_vs; vh1 <= vh0; dh0 <= video_de; dh1 <= dh0;
    end
  end

  always @(negedge video_clk) begin
    if (rst_n) begin
      chk("vs_dly", 80'(matrix_vs), 80'(vh1));
      chk("de_dly", 80'(matrix_de), 80'(dh1));
      if (matrix_de) begin
        run++;
        if (sb_q.size() == 0) chk("sb_under", 80'd1, 80'd0);
        else chk("win", 80'(win), 80'(sb_q.pop_front()));
      end else if (run > 0) begin
        if (len_q.size() == 0) chk("len_under", 80'd1, 80'd0);
        else chk("de_len", 80'(run), 80'(len_q.pop_front()));
        run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; video_vs = 1'b0; video_de = 1'b0; video_data = 8'd0;
    for (int i = 0; i < 6; i++) begin
      video_de = 1'($urandom); video_vs = 1'($urandom); video_data = 8'($urandom);
      @(negedge video_clk);
      chk("rst_out", 80'({matrix_vs, matrix_de, win}), 80'd0);
      @(posedge video_clk); #1;
    end
    // release in the middle of a line
    rst_n = 1'b1;
    mrow = 0; mcol = 0; m_pde = 1'b0; m_pvs = 1'b0;
    for (int c = 0; c < 3; c++) drive(1'b1, 1'b0, 8'($urandom_range(1, 255)));
    len_q.push_back(3);
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    vs_pulse();
    for (int r = 0; r < 4; r++) line(4, 16 * r, 1'b0);
    drive(1'b0, 1'b0, 8'd0);
    vs_pulse();
    // over-long row 2; frame ends with de fall and vs rise together
    line(4, 8'h40, 1'b0);
    line(4, 8'h50, 1'b0);
    line(6, 8'h60, 1'b0);
    line(4, 8'h70, 1'b1);
    drive(1'b0, 1'b0, 8'd0);
    for (int r = 0; r < 3; r++) line(4, 8'h80 + 16 * r, 1'b0);
    vs_pulse();
    for (int r = 0; r < 2; r++) line(4, 8'hC0 + 16 * r, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 8'd0);
    chk("sb_empty", 80'(sb_q.size()), 80'd0);
    chk("len_empty", 80'(len_q.size()), 80'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
